// File: rtl/interp_sweep_ctrl_if.sv
// Output pair stream of the sweep controller: one registered {x, y} pair per transfer.
// master drives out_valid/out_x/out_y, slave drives out_ready.
// A transfer happens on a rising clock edge where out_valid && out_ready.
interface interp_sweep_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_x;
    logic [DATA_W-1:0] out_y;

    modport master (
        output out_valid,
        output out_x,
        output out_y,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_x,
        input  out_y,
        output out_ready
    );
endinterface

// File: rtl/interp_sweep_ctrl.sv
// Purpose: sweeps an ascending x ramp (start_x..end_x, stride step) into the LUT
//          interpolator and registers each {x, y} pair into a one-deep output stage.
// Latency: start accepted in cycle N, RUN from N+1, first out_valid in N+2; one pair/cycle.
// Backpressure: a pending pair with out_ready low freezes the ramp (x, pair, valid held).
//
// Ports: clk, rst_n (async active-low); start/start_x/end_x/step command inputs;
//        x_out -> interpolator, y_in <- interpolator (combinational in x_out);
//        ob (interp_sweep_ctrl_if.master) output pair stream; busy, done, cfg_err status.
// Optional: define SWEEP_CHECKSUM_EN to add a SUM_W-bit checksum output that sums
//           every accepted out_y since the last accepted start.
module interp_sweep_ctrl #(
    parameter int DATA_W = 8
`ifdef SWEEP_CHECKSUM_EN
    ,
    parameter int SUM_W  = 16
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   start_x,
    input  logic [DATA_W-1:0]   end_x,
    input  logic [DATA_W-1:0]   step,
    output logic [DATA_W-1:0]   x_out,
    input  logic [DATA_W-1:0]   y_in,
    interp_sweep_ctrl_if.master ob,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
`ifdef SWEEP_CHECKSUM_EN
    ,
    output logic [SUM_W-1:0]    checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] cur_x;
    logic [DATA_W-1:0] end_r;
    logic [DATA_W-1:0] step_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_x_r;
    logic [DATA_W-1:0] out_y_r;

    logic              slot_free;
    logic              accept;
    logic [DATA_W:0]   nxt;

    // The slot is free when empty or when its current pair leaves this cycle,
    // so a capture and an acceptance can coincide without a bubble.
    assign slot_free = !out_valid_r || ob.out_ready;
    assign accept    = out_valid_r && ob.out_ready;

    // One extra bit so a stride past the top code is seen as "beyond end_x"
    // rather than wrapping back to a small x.
    assign nxt = {1'b0, cur_x} + {1'b0, step_r};

    assign x_out        = cur_x;
    assign ob.out_valid = out_valid_r;
    assign ob.out_x     = out_x_r;
    assign ob.out_y     = out_y_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cur_x       <= '0;
            end_r       <= '0;
            step_r      <= '0;
            out_valid_r <= 1'b0;
            out_x_r     <= '0;
            out_y_r     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        end_r  <= end_x;
                        step_r <= (step == '0) ? DATA_W'(1) : step;
                        cur_x  <= start_x;
                        if (start_x <= end_x) begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end else begin
                            // Empty range: report and finish without emitting anything.
                            cfg_err <= 1'b1;
                            done    <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (slot_free) begin
                        out_x_r     <= cur_x;
                        out_y_r     <= y_in;
                        out_valid_r <= 1'b1;
                        if (nxt > {1'b0, end_r}) begin
                            state <= S_DRAIN;
                        end else begin
                            cur_x <= nxt[DATA_W-1:0];
                        end
                    end
                end
                S_DRAIN: begin
                    if (accept) begin
                        out_valid_r <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SWEEP_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (state == S_IDLE && start) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + SUM_W'(out_y_r);
        end
    end
`endif

endmodule

// File: tb/tb_interp_sweep_ctrl.sv
// Directed bench for interp_sweep_ctrl: a table of sweep commands with hand-computed
// pair counts, plus hand-written sequences for start-while-busy and reset mid-sweep.
// A small interpolator stand-in feeds y_in combinationally from x_out.
module tb_interp_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] start_x;
    logic [7:0] end_x;
    logic [7:0] step;
    logic [7:0] x_out;
    logic [7:0] y_in;
    logic       busy;
    logic       done;
    logic       cfg_err;
`ifdef SWEEP_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    interp_sweep_ctrl_if #(.DATA_W(8)) o_if ();

    interp_sweep_ctrl #(.DATA_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .start_x (start_x),
        .end_x   (end_x),
        .step    (step),
        .x_out   (x_out),
        .y_in    (y_in),
        .ob      (o_if.master),
        .busy    (busy),
        .done    (done),
        .cfg_err (cfg_err)
`ifdef SWEEP_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    // Interpolator stand-in: any fixed, x-dependent curve will do.
    function automatic logic [7:0] ymodel(input logic [7:0] x);
        logic [15:0] sq;
        sq = 16'(x) * 16'(x);
        return sq[15:8] ^ x ^ 8'h3C;
    endfunction

    assign y_in = ymodel(x_out);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [15:0] sum_model;

    typedef struct {
        logic [7:0] sx;
        logic [7:0] ex;
        logic [7:0] st;
        int         cnt;
        int         stall;
        bit         err;
        bit         intrude;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_vec(input vec_t v);
        int cnt, first_v, last_acc, done_cyc, start_cyc, stepe;
        logic [7:0] exp_x;
        stepe = (v.st == 8'd0) ? 1 : int'(v.st);
        sum_model = 16'd0;
        start = 1'b1; start_x = v.sx; end_x = v.ex; step = v.st;
        o_if.out_ready = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        chk("cfg_err_n1", int'(cfg_err), int'(v.err));
        chk("valid_n1", int'(o_if.out_valid), 0);
        if (v.err) chk("done_err", int'(done), 1);
        else       chk("busy_n1", int'(busy), 1);
`ifdef SWEEP_CHECKSUM_EN
        chk("checksum_clear", int'(checksum), 0);
`endif
        cnt = 0; first_v = -1; last_acc = -1; done_cyc = -1;
        for (int i = 0; i < 600; i++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (o_if.out_valid && first_v < 0) first_v = cyc;
            o_if.out_ready = !(first_v >= 0 && cyc < first_v + v.stall);
            if (v.intrude && cyc == start_cyc + 3) begin
                start = 1'b1; start_x = 8'd100; end_x = 8'd120; step = 8'd2;
            end else begin
                start = 1'b0;
            end
            if (o_if.out_valid) begin
                exp_x = 8'(int'(v.sx) + cnt * stepe);
                chk("pair_x", int'(o_if.out_x), int'(exp_x));
                chk("pair_y", int'(o_if.out_y), int'(ymodel(exp_x)));
                if (o_if.out_ready) begin
                    cnt++;
                    last_acc = cyc;
                    sum_model = sum_model + 16'(o_if.out_y);
                end
            end
            tick();
        end
        start = 1'b0;
        o_if.out_ready = 1'b1;
        if (done_cyc < 0) chk("done_timeout", 0, 1);
        chk("pair_count", cnt, v.cnt);
        if (!v.err) begin
            chk("first_valid_lat", first_v - start_cyc, 2);
            chk("done_after_last", done_cyc - last_acc, 1);
            chk("sweep_cycles", done_cyc - first_v, v.cnt + v.stall);
        end
`ifdef SWEEP_CHECKSUM_EN
        chk("checksum", int'(checksum), int'(sum_model));
`endif
        tick();
        chk("done_one_cycle", int'(done), 0);
        chk("cfg_err_one_cycle", int'(cfg_err), 0);
        chk("busy_after", int'(busy), 0);
        chk("valid_after", int'(o_if.out_valid), 0);
    endtask

    initial begin
        int acc;
        // sx, ex, step, pairs, stall, err, intrude
        vecs[0] = '{8'd0,   8'd12,  8'd4,  4, 0, 1'b0, 1'b0}; // basic ramp
        vecs[1] = '{8'd250, 8'd255, 8'd4,  2, 0, 1'b0, 1'b0}; // 250,254 then carry stop
        vecs[2] = '{8'd7,   8'd7,   8'd0,  1, 0, 1'b0, 1'b0}; // single point
        vecs[3] = '{8'd5,   8'd8,   8'd0,  4, 0, 1'b0, 1'b0}; // step 0 -> 1
        vecs[4] = '{8'd0,   8'd3,   8'd1,  4, 3, 1'b0, 1'b0}; // backpressure
        vecs[5] = '{8'd9,   8'd3,   8'd1,  0, 0, 1'b1, 1'b0}; // config error
        vecs[6] = '{8'd0,   8'd255, 8'd85, 4, 0, 1'b0, 1'b0}; // 0,85,170,255
        vecs[7] = '{8'd10,  8'd20,  8'd3,  4, 0, 1'b0, 1'b0}; // endpoint off-stride
        vecs[8] = '{8'd0,   8'd5,   8'd1,  6, 0, 1'b0, 1'b1}; // start while busy

        rst_n = 1'b0; start = 1'b0; start_x = '0; end_x = '0; step = '0;
        o_if.out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", int'(o_if.out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_x_out", int'(x_out), 0);
        chk("rst_out_x", int'(o_if.out_x), 0);
        chk("rst_out_y", int'(o_if.out_y), 0);
`ifdef SWEEP_CHECKSUM_EN
        chk("rst_checksum", int'(checksum), 0);
`endif
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 9; k++) begin
            run_vec(vecs[k]);
        end

        // Reset mid-sweep after two accepted pairs of a 0..200 sweep.
        start = 1'b1; start_x = 8'd0; end_x = 8'd200; step = 8'd1;
        tick();
        start = 1'b0;
        acc = 0;
        for (int i = 0; i < 20 && acc < 2; i++) begin
            if (o_if.out_valid && o_if.out_ready) acc++;
            tick();
        end
        chk("mid_pairs", acc, 2);
        chk("mid_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(o_if.out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_x_out", int'(x_out), 0);
        chk("mid_rst_out_x", int'(o_if.out_x), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_done", int'(done), 0);
        end
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", int'(done), 0);
        chk("post_rst_busy", int'(busy), 0);

        // Normal operation after reset; also clears a checksum left from earlier.
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/interp_sweep_ctrl.md
Name: interp_sweep_ctrl

Overview:
- Upstream sequencer for the 8-bit LUT quadratic interpolator.
- On a start command it generates an ascending ramp of x codes (start_x to end_x, stride step) and drives them to the interpolator.
- It samples the interpolator's combinational y result in the same cycle and registers each {x, y} pair into a one-deep output stage with valid/ready handshake.
- Used for table sweeps, characterisation and curve dumps.

Parameters:
- DATA_W, 8, width of x and y codes; the interpolator is fixed at 8.
- SUM_W, 16, checksum accumulator width; used only with SWEEP_CHECKSUM_EN.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command; sampled only in IDLE.
- start_x  in  DATA_W  first x code; latched on accepted start.
- end_x  in  DATA_W  last permissible x code; latched on accepted start.
- step  in  DATA_W  x stride; latched on accepted start; 0 is treated as 1.
- x_out  out  DATA_W  x code to interpolator input.
- y_in  in  DATA_W  interpolator output; combinational function of x_out.
- out_valid  out  1  out_x/out_y hold a valid pair.
- out_ready  in  1  consumer accepts the pair when out_valid && out_ready.
- out_x  out  DATA_W  registered x of the pair.
- out_y  out  DATA_W  registered y of the pair.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at sweep completion.
- cfg_err  out  1  one-cycle pulse when start_x > end_x.

Behaviour:
- Reset values: x_out, out_x, out_y = 0; out_valid, busy, done, cfg_err = 0; state = IDLE.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 latches start_x, end_x, step (0 becomes 1) and loads cur_x = start_x.
  - If start_x <= end_x: go to RUN.
  - Else: pulse cfg_err and done in the next cycle, emit no pairs, stay IDLE.
- x_out = cur_x register at all times.
- RUN, output slot free (out_valid==0 or out_ready==1) in a cycle:
  - capture out_x <= cur_x, out_y <= y_in; set out_valid <= 1.
  - next = cur_x + step, computed at DATA_W+1 bits.
  - If next > end_x (including carry past 255): go to DRAIN, cur_x unchanged.
  - Else: cur_x <= next.
- RUN, slot not free: hold cur_x, out_x, out_y and out_valid stable; no capture.
- DRAIN:
  - When out_valid && out_ready: clear out_valid, pulse done for one cycle, return to IDLE.
  - A capture and its acceptance in the same cycle both occur (accept old pair, load new pair).
- Latency and throughput:
  - start accepted at cycle N; RUN from N+1; first out_valid at N+2.
  - With out_ready held high: one pair per cycle.
  - done pulses one cycle after the last pair is accepted.
- start while busy is ignored; busy = (state != IDLE).
- Sweep length = floor((end_x - start_x)/step) + 1 pairs; the endpoint is emitted only if it lies on the stride.
- Reset mid-sweep: immediate return to reset values; the in-flight pair is dropped; no done pulse.
- No x code outside [start_x, end_x] is ever captured.

Optional Feature:
- Macro: SWEEP_CHECKSUM_EN.
- Defined:
  - Adds output port checksum [SUM_W-1:0].
  - Cleared on accepted start.
  - Adds out_y (zero-extended) on each accepted handshake, modulo 2^SUM_W.
  - Holds its value after done until the next start; reset value 0.
- Undefined: no port, no accumulator; all other behaviour identical.

Test Plan:
- Basic ramp: start_x=0, end_x=12, step=4, out_ready=1 -> out_x = 0,4,8,12 on consecutive cycles starting 2 cycles after start; each out_y equals the interpolator model output for that x; done one cycle after the 12 pair; busy low afterwards.
- Overflow stop: start_x=250, end_x=255, step=4 -> exactly two pairs, x=250 and 254, then done; no wrap to 2.
- Step zero / single point:
  - start_x=end_x=7, step=0 -> one pair, x=7, then done.
  - start_x=5, end_x=8, step=0 -> x = 5,6,7,8.
- Backpressure: ramp 0..3 step 1 with out_ready low for 3 cycles after the first valid -> out_x=0 and out_y held stable while stalled; sequence resumes 1,2,3 with no loss or duplication.
- Config error and ignore: start_x=9, end_x=3 -> cfg_err and done pulse together, zero pairs. A second start asserted during a running sweep has no effect.
- Reset mid-sweep: assert rst_n=0 after 2 pairs of a 0..200 sweep -> out_valid=0, busy=0, x_out=0 immediately. With SWEEP_CHECKSUM_EN, checksum equals the sum of accepted out_y in the basic ramp and is cleared by the next start.
